// File: rtl/abc_input_debounce_pkg.sv
// abc_input_debounce_pkg
//   Shared constants for the slide-switch debouncer: the per-channel state
//   encoding, the channel count and the default build parameters.
package abc_input_debounce_pkg;

  // Per-channel debounce state, kept as plain constants so older tools and
  // waveform viewers show the raw encoding.
  typedef logic [0:0] ch_state_t;
  localparam ch_state_t ST_STABLE = 1'b0;
  localparam ch_state_t ST_COUNT  = 1'b1;

  localparam int NUM_CHANNELS            = 3;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_CNT_W           = 16;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/abc_input_debounce_if.sv
// abc_input_debounce_if
//   Bundles the three raw switch pins and the conditioned outputs.
//   master : drives sw_a/sw_b/sw_c, observes the clean levels
//   slave  : the debouncer, consumes raw pins and drives a/b/c/changed/stable
//   sw_a, sw_b, sw_c : raw switch levels, asynchronous to clk
//   a, b, c          : debounced levels, registered
//   changed          : one-cycle pulse in the first cycle any of a/b/c is new
//   stable           : high while no channel is counting
interface abc_input_debounce_if;
  logic sw_a;
  logic sw_b;
  logic sw_c;
  logic a;
  logic b;
  logic c;
  logic changed;
  logic stable;

  modport master (
    output sw_a, sw_b, sw_c,
    input  a, b, c, changed, stable
  );

  modport slave (
    input  sw_a, sw_b, sw_c,
    output a, b, c, changed, stable
  );
endinterface

// File: rtl/abc_input_debounce_channel.sv
// debounce_channel
//   One switch channel: a SYNC_STAGES-deep synchroniser followed by a two-state
//   debounce FSM. The level only moves after the synchronised input has
//   disagreed with it on DEBOUNCE_CYCLES+1 consecutive edges (the first edge
//   starts the count, the last one commits the new value).
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   raw     : raw switch pin
//   level   : debounced level, registered
//   flip    : combinational, high in the cycle whose closing edge updates level
//   settled : high while the FSM is in ST_STABLE
module debounce_channel
  import abc_input_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic flip,
  output logic settled
);

  localparam logic [CNT_W-1:0] TARGET = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   disagree;
  ch_state_t              state;
  logic [CNT_W-1:0]       cnt;

  // Synchroniser shift chain; bit 0 is the metastability-exposed flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign synced   = sync_q[SYNC_STAGES-1];
  assign disagree = (synced != level);

  // The commit condition is exposed so the top can register one shared
  // change strobe aligned with the new level.
  assign flip    = (state == ST_COUNT) && disagree && (cnt == TARGET);
  assign settled = (state == ST_STABLE);

  // Debounce FSM. Any agreeing sample during a count is a bounce and throws
  // the count away; the counter stops at TARGET so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_STABLE;
      cnt   <= '0;
      level <= 1'b0;
    end else if (state == ST_STABLE) begin
      if (disagree) begin
        state <= ST_COUNT;
        cnt   <= CNT_W'(1);
      end
    end else begin
      if (!disagree) begin
        state <= ST_STABLE;
        cnt   <= '0;
      end else if (cnt == TARGET) begin
        level <= synced;
        state <= ST_STABLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/abc_input_debounce.sv
// abc_input_debounce
//   Conditions three raw slide switches into clean levels for the downstream
//   3-input logic stage, plus a change strobe and an all-settled flag.
//   clk   : system clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of abc_input_debounce_if (sw_a..sw_c in,
//           a, b, c, changed, stable out)
module abc_input_debounce
  import abc_input_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  abc_input_debounce_if.slave  bus
);

  logic [NUM_CHANNELS-1:0] flip;
  logic [NUM_CHANNELS-1:0] settled;
  logic                    changed_q;

  debounce_channel #(
    .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch_a (
    .clk(clk), .rst_n(rst_n), .raw(bus.sw_a),
    .level(bus.a), .flip(flip[0]), .settled(settled[0])
  );

  debounce_channel #(
    .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch_b (
    .clk(clk), .rst_n(rst_n), .raw(bus.sw_b),
    .level(bus.b), .flip(flip[1]), .settled(settled[1])
  );

  debounce_channel #(
    .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch_c (
    .clk(clk), .rst_n(rst_n), .raw(bus.sw_c),
    .level(bus.c), .flip(flip[2]), .settled(settled[2])
  );

  // Registering the OR lines the pulse up with the levels it announces and
  // merges simultaneous flips on several channels into a single pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |flip;
    end
  end

  assign bus.changed = changed_q;
  assign bus.stable  = &settled;

endmodule

// File: tb/tb_abc_input_debounce.sv
// tb_abc_input_debounce
//   Directed vector table, hand-written reset/parameter sequences and a
//   randomized run against a run-length reference model.
//   Outputs are compared as {c, b, a, changed, stable}.
module tb_abc_input_debounce;

  localparam int SYNC = 2;
  localparam int DC   = 4;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  abc_input_debounce_if bus0 ();
  abc_input_debounce_if bus1 ();

  abc_input_debounce #(
    .SYNC_STAGES(SYNC), .CNT_W(CW), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  abc_input_debounce #(
    .SYNC_STAGES(SYNC), .CNT_W(CW), .DEBOUNCE_CYCLES(1)
  ) dut_fast (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  typedef struct {
    logic       rst_n;
    logic [2:0] sw;
    logic [2:0] exp_abc;
    logic       exp_changed;
    logic       exp_stable;
  } vec_t;

  vec_t vec_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: the synchronised value seen by the debouncer is the raw
  // value delayed SYNC edges; a level moves when that value has differed from
  // it on DC+1 consecutive edges.
  logic [2:0] m_q [SYNC];
  logic [2:0] m_x;
  int         m_run [3];
  logic       m_changed;

  function automatic void add(input logic r, input logic [2:0] sw, input logic [2:0] e,
                              input logic ch, input logic st, input int n);
    vec_t v;
    v.rst_n = r; v.sw = sw; v.exp_abc = e; v.exp_changed = ch; v.exp_stable = st;
    for (int i = 0; i < n; i++) vec_q.push_back(v);
  endfunction

  function automatic logic [4:0] dut0_out();
    return {bus0.c, bus0.b, bus0.a, bus0.changed, bus0.stable};
  endfunction

  function automatic logic [4:0] dut1_out();
    return {bus1.c, bus1.b, bus1.a, bus1.changed, bus1.stable};
  endfunction

  function automatic logic model_stable();
    return (m_run[0] == 0) && (m_run[1] == 0) && (m_run[2] == 0);
  endfunction

  function automatic void model_edge(input logic r, input logic [2:0] sw);
    logic [2:0] d;
    logic       any_flip;
    if (!r) begin
      for (int i = 0; i < SYNC; i++) m_q[i] = '0;
      m_x = '0;
      for (int ch = 0; ch < 3; ch++) m_run[ch] = 0;
      m_changed = 1'b0;
      return;
    end
    d = m_q[SYNC-1];
    any_flip = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      if (d[ch] != m_x[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == DC + 1) begin
          m_x[ch]   = d[ch];
          m_run[ch] = 0;
          any_flip  = 1'b1;
        end
      end else begin
        m_run[ch] = 0;
      end
    end
    for (int i = SYNC - 1; i > 0; i--) m_q[i] = m_q[i-1];
    m_q[0] = sw;
    m_changed = any_flip;
  endfunction

  // Drive one cycle's inputs on the main DUT, then move to just after the edge.
  task automatic applyStimulus(input logic r, input logic [2:0] sw);
    rst_n     = r;
    bus0.sw_a = sw[0];
    bus0.sw_b = sw[1];
    bus0.sw_c = sw[2];
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [4:0] got, input logic [4:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got {c,b,a,changed,stable}=%b expected %b", name, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0] cur_sw;
    logic       r;

    rst_n     = 1'b0;
    bus0.sw_a = 1'b0; bus0.sw_b = 1'b0; bus0.sw_c = 1'b0;
    bus1.sw_a = 1'b0; bus1.sw_b = 1'b0; bus1.sw_c = 1'b0;

    // Reset with switches high, clean rise on a, bounce on b, fall on a,
    // simultaneous rise on a and c.
    add(0, 3'b111, 3'b000, 0, 1, 3);
    add(1, 3'b000, 3'b000, 0, 1, 2);
    add(1, 3'b001, 3'b000, 0, 1, 2);
    add(1, 3'b001, 3'b000, 0, 0, 4);
    add(1, 3'b001, 3'b001, 1, 1, 1);
    add(1, 3'b001, 3'b001, 0, 1, 1);
    add(1, 3'b011, 3'b001, 0, 1, 2);
    add(1, 3'b011, 3'b001, 0, 0, 1);
    add(1, 3'b001, 3'b001, 0, 0, 2);
    add(1, 3'b001, 3'b001, 0, 1, 2);
    add(1, 3'b000, 3'b001, 0, 1, 2);
    add(1, 3'b000, 3'b001, 0, 0, 4);
    add(1, 3'b000, 3'b000, 1, 1, 1);
    add(1, 3'b000, 3'b000, 0, 1, 1);
    add(1, 3'b101, 3'b000, 0, 1, 2);
    add(1, 3'b101, 3'b000, 0, 0, 4);
    add(1, 3'b101, 3'b101, 1, 1, 1);
    add(1, 3'b101, 3'b101, 0, 1, 1);

    foreach (vec_q[i]) begin
      applyStimulus(vec_q[i].rst_n, vec_q[i].sw);
      checkOutput($sformatf("table[%0d]", i), dut0_out(),
                  {vec_q[i].exp_abc, vec_q[i].exp_changed, vec_q[i].exp_stable});
    end

    // Reset in the middle of a count on c.
    applyStimulus(0, 3'b000);
    applyStimulus(0, 3'b000);
    checkOutput("midreset_pre", dut0_out(), 5'b00001);
    applyStimulus(1, 3'b000);
    applyStimulus(1, 3'b000);
    for (int k = 1; k <= 3; k++) applyStimulus(1, 3'b100);
    checkOutput("midreset_counting", dut0_out(), 5'b00000);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_async", dut0_out(), 5'b00001);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(0, 3'b100);
      checkOutput($sformatf("midreset_held[%0d]", k), dut0_out(), 5'b00001);
    end
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1, 3'b100);
      if (k <= 2)      checkOutput($sformatf("midreset_post[%0d]", k), dut0_out(), 5'b00001);
      else if (k <= 6) checkOutput($sformatf("midreset_post[%0d]", k), dut0_out(), 5'b00000);
      else if (k == 7) checkOutput($sformatf("midreset_post[%0d]", k), dut0_out(), 5'b10011);
      else             checkOutput($sformatf("midreset_post[%0d]", k), dut0_out(), 5'b10001);
    end

    // Single-cycle debounce build: rise then fall on a, 3 edges each.
    bus1.sw_a = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k <= 2)      checkOutput($sformatf("fast_rise[%0d]", k), dut1_out(), 5'b00001);
      else if (k == 3) checkOutput($sformatf("fast_rise[%0d]", k), dut1_out(), 5'b00000);
      else if (k == 4) checkOutput($sformatf("fast_rise[%0d]", k), dut1_out(), 5'b00111);
      else             checkOutput($sformatf("fast_rise[%0d]", k), dut1_out(), 5'b00101);
    end
    bus1.sw_a = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k <= 2)      checkOutput($sformatf("fast_fall[%0d]", k), dut1_out(), 5'b00101);
      else if (k == 3) checkOutput($sformatf("fast_fall[%0d]", k), dut1_out(), 5'b00100);
      else             checkOutput($sformatf("fast_fall[%0d]", k), dut1_out(), 5'b00011);
    end

    // Randomized switching with occasional resets against the model.
    cur_sw = 3'b000;
    for (int n = 0; n < 3000; n++) begin
      r = (n < 2 || $urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      for (int ch = 0; ch < 3; ch++)
        if ($urandom_range(0, 7) == 0) cur_sw[ch] = ~cur_sw[ch];
      applyStimulus(r, cur_sw);
      model_edge(r, cur_sw);
      checkOutput($sformatf("random[%0d]", n), dut0_out(), {m_x, m_changed, model_stable()});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
